// File: rtl/video_mnist_gray_binarize_if.sv
// AXI4-Stream video link shared by the gray/binarize stage.
// The slave view carries RGB in; the master view carries luma plus the binary flag out.
interface video_mnist_gray_binarize_if #(
  parameter int unsigned TUSER_WIDTH = 1,
  parameter int unsigned TDATA_WIDTH = 8
);
  logic [TUSER_WIDTH-1:0] tuser;
  logic                   tlast;
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tbinary;
  logic                   tvalid;
  logic                   tready;

  modport master (output tuser, tlast, tdata, tbinary, tvalid, input tready);
  modport slave  (input tuser, tlast, tdata, tvalid, output tready);
endinterface

// File: rtl/video_mnist_gray_binarize.sv
// RGB -> 8-bit luma with per-frame shadowed threshold/invert, 3-stage pipeline with backpressure.
// Optional per-frame ones counter enabled by macro VIDEO_MNIST_GRAY_BINARIZE_STAT_EN.
module video_mnist_gray_binarize #(
  parameter int unsigned TUSER_WIDTH    = 1,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned STAT_WIDTH     = 20,
  parameter logic [7:0]  INIT_PARAM_TH  = 8'd127,
  parameter logic        INIT_PARAM_INV = 1'b0
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [7:0]                     param_th,
  input  logic                           param_inv,
  video_mnist_gray_binarize_if.slave     s_axi4s,
  video_mnist_gray_binarize_if.master    m_axi4s
`ifdef VIDEO_MNIST_GRAY_BINARIZE_STAT_EN
  ,
  output logic [STAT_WIDTH-1:0]          stat_ones,
  output logic                           stat_valid
`endif
);

  localparam int unsigned PROD_WIDTH = 16;

  if (DATA_WIDTH != 8 || STAT_WIDTH == 0) begin : g_param_err
    $error("video_mnist_gray_binarize: DATA_WIDTH must be 8 and STAT_WIDTH nonzero");
  end

  // Sideband travelling with each beat, including the shadow settings it was captured with
  typedef struct packed {
    logic [TUSER_WIDTH-1:0] tuser;
    logic                   tlast;
    logic [7:0]             th;
    logic                   inv;
  } side_t;

  logic                  cke;
  logic                  sof_in;
  logic [7:0]            th_r;
  logic                  inv_r;
  logic [7:0]            th_in;
  logic                  inv_in;

  logic                  v1;
  side_t                 side1;
  logic [PROD_WIDTH-1:0] prod_r;
  logic [PROD_WIDTH-1:0] prod_g;
  logic [PROD_WIDTH-1:0] prod_b;

  logic                  v2;
  side_t                 side2;
  logic [7:0]            y2;

  logic [PROD_WIDTH-1:0] sum_c;
  logic [7:0]            y_c;

  assign cke            = ~m_axi4s.tvalid | m_axi4s.tready;
  assign s_axi4s.tready = cke;
  assign sof_in         = s_axi4s.tvalid & cke & s_axi4s.tuser[0];

  // A start-of-frame beat already uses the freshly sampled parameters
  assign th_in  = sof_in ? param_th  : th_r;
  assign inv_in = sof_in ? param_inv : inv_r;

  // Max sum is 65280, so 16 bits never overflow
  assign sum_c = prod_r + prod_g + prod_b;
  assign y_c   = 8'(sum_c >> 8);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      th_r            <= INIT_PARAM_TH;
      inv_r           <= INIT_PARAM_INV;
      v1              <= 1'b0;
      side1           <= '0;
      prod_r          <= '0;
      prod_g          <= '0;
      prod_b          <= '0;
      v2              <= 1'b0;
      side2           <= '0;
      y2              <= '0;
      m_axi4s.tvalid  <= 1'b0;
      m_axi4s.tuser   <= '0;
      m_axi4s.tlast   <= 1'b0;
      m_axi4s.tdata   <= '0;
      m_axi4s.tbinary <= 1'b0;
    end else begin
      if (sof_in) begin
        th_r  <= param_th;
        inv_r <= param_inv;
      end
      if (cke) begin
        v1             <= s_axi4s.tvalid;
        v2             <= v1;
        m_axi4s.tvalid <= v2;
        if (s_axi4s.tvalid) begin
          side1  <= '{tuser: s_axi4s.tuser, tlast: s_axi4s.tlast, th: th_in, inv: inv_in};
          prod_r <= PROD_WIDTH'(s_axi4s.tdata[7:0])   * PROD_WIDTH'(77);
          prod_g <= PROD_WIDTH'(s_axi4s.tdata[15:8])  * PROD_WIDTH'(150);
          prod_b <= PROD_WIDTH'(s_axi4s.tdata[23:16]) * PROD_WIDTH'(29);
        end
        if (v1) begin
          side2 <= side1;
          y2    <= y_c;
        end
        if (v2) begin
          m_axi4s.tuser   <= side2.tuser;
          m_axi4s.tlast   <= side2.tlast;
          m_axi4s.tdata   <= y2;
          m_axi4s.tbinary <= (y2 > side2.th) ^ side2.inv;
        end
      end
    end
  end

`ifdef VIDEO_MNIST_GRAY_BINARIZE_STAT_EN
  logic                  out_hs;
  logic [STAT_WIDTH-1:0] ones_cnt;

  assign out_hs = m_axi4s.tvalid & m_axi4s.tready;

  // Publish on each output start-of-frame; the SOF beat itself seeds the next frame's count
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ones_cnt   <= '0;
      stat_ones  <= '0;
      stat_valid <= 1'b0;
    end else begin
      stat_valid <= 1'b0;
      if (out_hs) begin
        if (m_axi4s.tuser[0]) begin
          stat_ones  <= ones_cnt;
          stat_valid <= 1'b1;
          ones_cnt   <= STAT_WIDTH'(m_axi4s.tbinary);
        end else if (m_axi4s.tbinary && (ones_cnt != '1)) begin
          ones_cnt <= ones_cnt + STAT_WIDTH'(1);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_video_mnist_gray_binarize.sv
// Scoreboard bench for video_mnist_gray_binarize: directed vectors, backpressure, mid-frame reset.
module tb_video_mnist_gray_binarize;

  logic       aclk = 1'b0;
  logic       aresetn;
  logic [7:0] param_th;
  logic       param_inv;

  always #5 aclk = ~aclk;

  video_mnist_gray_binarize_if #(.TUSER_WIDTH(1), .TDATA_WIDTH(24)) s_if ();
  video_mnist_gray_binarize_if #(.TUSER_WIDTH(1), .TDATA_WIDTH(8))  m_if ();

  assign s_if.tbinary = 1'b0;

`ifdef VIDEO_MNIST_GRAY_BINARIZE_STAT_EN
  logic [19:0] stat_ones;
  logic        stat_valid;
`endif

  video_mnist_gray_binarize dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .param_th  (param_th),
    .param_inv (param_inv),
    .s_axi4s   (s_if),
    .m_axi4s   (m_if)
`ifdef VIDEO_MNIST_GRAY_BINARIZE_STAT_EN
    ,
    .stat_ones (stat_ones),
    .stat_valid(stat_valid)
`endif
  );

  typedef struct packed {
    logic        tuser;
    logic        tlast;
    logic [7:0]  y;
    logic        bin;
    logic        lat;
    logic [31:0] cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  logic        hold_ready = 1'b0;
  logic        bp_en = 1'b0;
  logic        lat_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] gray(input logic [7:0] v);
    return {v, v, v};
  endfunction

  function automatic logic [7:0] luma(input logic [23:0] d);
    int unsigned s;
    s = 77 * int'(d[7:0]) + 150 * int'(d[15:8]) + 29 * int'(d[23:16]);
    return 8'(s / 256);
  endfunction

  always @(posedge aclk) cyc <= cyc + 1;

  // Downstream ready: always, forced low, or random ~30% low
  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      m_if.tready = hold_ready ? 1'b0 : (bp_en ? ($urandom_range(0, 9) >= 3) : 1'b1);
    end
  end

  // Output monitor: stall stability and scoreboard compare
  logic       stall_prev = 1'b0;
  logic [11:0] held;
  always @(negedge aclk) begin
    if (!aresetn) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        chk("stall_hold", {20'd0, m_if.tuser, m_if.tlast, m_if.tdata, m_if.tbinary, m_if.tvalid},
            {20'd0, held});
      stall_prev = m_if.tvalid & ~m_if.tready;
      held = {m_if.tuser, m_if.tlast, m_if.tdata, m_if.tbinary, m_if.tvalid};
      if (m_if.tvalid && m_if.tready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("tdata", 32'(m_if.tdata), 32'(e.y));
          chk("tbinary", 32'(m_if.tbinary), 32'(e.bin));
          chk("tuser_tlast", 32'({m_if.tuser, m_if.tlast}), 32'({e.tuser, e.tlast}));
          if (e.lat) chk("latency", cyc - e.cyc, 32'd3);
        end
      end
    end
  end

`ifdef VIDEO_MNIST_GRAY_BINARIZE_STAT_EN
  logic [19:0] stat_exp[$];
  logic        stat_chk = 1'b0;
  always @(negedge aclk) begin
    if (aresetn && stat_chk && stat_valid) begin
      if (stat_exp.size() == 0) chk("stat_extra", 32'd1, 32'd0);
      else                      chk("stat_ones", 32'(stat_ones), 32'(stat_exp.pop_front()));
    end
  end
`endif

  task automatic send(input logic [23:0] d, input logic sof, input logic eol,
                      input logic [7:0] y, input logic bin);
    exp_t e;
    int   t;
    t = 0;
    s_if.tdata  = d;
    s_if.tuser  = sof;
    s_if.tlast  = eol;
    s_if.tvalid = 1'b1;
    forever begin
      @(negedge aclk);
      if (s_if.tready) begin
        e.tuser = sof; e.tlast = eol; e.y = y; e.bin = bin; e.lat = lat_en; e.cyc = cyc;
        sb.push_back(e);
        break;
      end
      t++;
      if (t > 1000) begin
        chk("send_timeout", 32'd1, 32'd0);
        break;
      end
      @(posedge aclk);
      #1;
    end
    @(posedge aclk);
    #1;
    s_if.tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    s_if.tvalid = 1'b0;
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 3000) begin
      @(posedge aclk);
      t++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
    @(posedge aclk);
    #1;
  endtask

  task automatic pulse_reset();
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    aresetn     = 1'b0;
    param_th    = 8'd127;
    param_inv   = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tuser  = '0;
    s_if.tlast  = 1'b0;
    #1;
    chk("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    chk("rst_s_tready", 32'(s_if.tready), 32'd1);
    chk("rst_m_payload", 32'({m_if.tuser, m_if.tlast, m_if.tdata, m_if.tbinary}), 32'd0);
`ifdef VIDEO_MNIST_GRAY_BINARIZE_STAT_EN
    chk("rst_stat", 32'({stat_ones, stat_valid}), 32'd0);
`endif
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // Grey ramp, 16 px per line, with latency check
    lat_en = 1'b1;
    for (int i = 0; i < 256; i++)
      send(gray(8'(i)), i == 0, (i % 16) == 15, 8'(i), i > 127);
    lat_en = 1'b0;
    drain();

    // Pure colours
    send(24'h0000FF, 1'b1, 1'b0, 8'd76,  1'b0);
    send(24'h00FF00, 1'b0, 1'b0, 8'd149, 1'b1);
    send(24'hFF0000, 1'b0, 1'b0, 8'd28,  1'b0);
    send(24'hFFFFFF, 1'b0, 1'b0, 8'd255, 1'b1);
    send(24'h000000, 1'b0, 1'b1, 8'd0,   1'b0);
    idle(2);

    // Shadow latch: mid-frame change ignored until next SOF; equality is not above
    send(gray(8'd100), 1'b1, 1'b0, 8'd100, 1'b0);
    param_th = 8'd10;
    send(gray(8'd11),  1'b0, 1'b0, 8'd11,  1'b0);
    send(gray(8'd200), 1'b0, 1'b1, 8'd200, 1'b1);
    send(gray(8'd11),  1'b1, 1'b0, 8'd11,  1'b1);
    send(gray(8'd10),  1'b0, 1'b0, 8'd10,  1'b0);
    send(gray(8'd12),  1'b0, 1'b1, 8'd12,  1'b1);
    param_inv = 1'b1;
    send(gray(8'd11),  1'b1, 1'b0, 8'd11,  1'b0);
    send(gray(8'd5),   1'b0, 1'b1, 8'd5,   1'b1);
    drain();

    // Random backpressure and input gaps
    param_th  = 8'd127;
    param_inv = 1'b0;
    bp_en     = 1'b1;
    for (int i = 0; i < 200; i++) begin
      logic [23:0] d;
      logic [7:0]  y;
      d = 24'($urandom);
      y = luma(d);
      send(d, i == 0, (i % 10) == 9, y, y > 8'd127);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    drain();
    bp_en = 1'b0;

    // Reset with a full, stalled pipeline
    hold_ready = 1'b1;
    @(posedge aclk);
    #2;
    param_th    = 8'd10;
    param_inv   = 1'b1;
    s_if.tdata  = gray(8'd200);
    s_if.tuser  = 1'b1;
    s_if.tlast  = 1'b0;
    s_if.tvalid = 1'b1;
    repeat (6) @(posedge aclk);
    #2;
    chk("full_m_tvalid", 32'(m_if.tvalid), 32'd1);
    aresetn = 1'b0;
    #1;
    chk("midrst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    chk("midrst_s_tready", 32'(s_if.tready), 32'd1);
    chk("midrst_m_payload", 32'({m_if.tuser, m_if.tlast, m_if.tdata, m_if.tbinary}), 32'd0);
    s_if.tvalid = 1'b0;
    sb.delete();
    repeat (2) @(posedge aclk);
    #1;
    aresetn    = 1'b1;
    hold_ready = 1'b0;
    // No SOF yet: shadow values must be back at 127 / non-inverted
    send(gray(8'd128), 1'b0, 1'b0, 8'd128, 1'b1);
    send(gray(8'd127), 1'b0, 1'b1, 8'd127, 1'b0);
    param_th  = 8'd127;
    param_inv = 1'b0;
    send(gray(8'd100), 1'b1, 1'b0, 8'd100, 1'b0);
    send(gray(8'd200), 1'b0, 1'b1, 8'd200, 1'b1);
    drain();

`ifdef VIDEO_MNIST_GRAY_BINARIZE_STAT_EN
    // Per-frame ones count: publishes 0, 20, 5
    pulse_reset();
    stat_exp.push_back(20'd0);
    stat_exp.push_back(20'd20);
    stat_exp.push_back(20'd5);
    stat_chk = 1'b1;
    for (int i = 0; i < 64; i++)
      send(gray(i < 20 ? 8'd200 : 8'd50), i == 0, (i % 8) == 7, i < 20 ? 8'd200 : 8'd50, i < 20);
    for (int i = 0; i < 64; i++)
      send(gray(i < 5 ? 8'd200 : 8'd50), i == 0, (i % 8) == 7, i < 5 ? 8'd200 : 8'd50, i < 5);
    send(gray(8'd50), 1'b1, 1'b0, 8'd50, 1'b0);
    drain();
    repeat (4) @(posedge aclk);
    #1;
    chk("stat_all_published", 32'(stat_exp.size()), 32'd0);
    stat_chk = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
